// File: rtl/score_bcd_accum.sv
// score_bcd_accum: BCD score accumulator with a double-buffered display.
// Adds ripple through a private working score, one digit per cycle, LSD first.
// The visible digits and high score are copied from the working score only
// during a one-cycle COMMIT that follows frame_start, so the score-draw stage
// never sees a half-finished add.
module score_bcd_accum #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  add_valid,
    output logic                  add_ready,
    input  logic [7:0]            add_points,
    input  logic                  frame_start,
    output logic [DIGITS*4-1:0]   digits,
    output logic [DIGITS*4-1:0]   hiscore,
    output logic                  overflow
);

    localparam int SW = DIGITS * 4;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);
    localparam logic [SW-1:0] ALL_NINES = {DIGITS{4'h9}};

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ADD    = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    // Latched add request, already clamped to legal BCD.
    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } pts_t;

    logic [1:0]    state;
    logic [SW-1:0] work;
    logic [IW-1:0] idx;
    logic          carry;
    logic          pend;
    pts_t          pts;

    logic [3:0]    cur_nib;
    logic [3:0]    inc_nib;
    logic [4:0]    sum;
    logic [4:0]    sum_m10;
    logic          sum_gt9;
    logic [3:0]    res_nib;
    logic [SW-1:0] next_work;
    logic          last_digit;
    logic          accept;

    // Any nibble above 9 is not a digit; treat it as the largest digit.
    function automatic logic [3:0] clamp9(input logic [3:0] n);
        return (n > 4'd9) ? 4'd9 : n;
    endfunction

    // Ready only when idle, nothing waiting to commit, and not being cleared/reset.
    assign add_ready = (state == S_IDLE) && !pend && !clear && !rst;
    assign accept    = add_valid && add_ready;
    assign last_digit = (idx == LAST_IDX);

    // One BCD digit add per cycle at position idx, plus the rewritten working score.
    always_comb begin
        cur_nib = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) cur_nib = work[k*4 +: 4];
        end
        if (idx == IW'(0))      inc_nib = pts.units;
        else if (idx == IW'(1)) inc_nib = pts.tens;
        else                    inc_nib = 4'd0;
        sum     = {1'b0, cur_nib} + {1'b0, inc_nib} + {4'd0, carry};
        sum_m10 = sum - 5'd10;
        sum_gt9 = (sum > 5'd9);
        res_nib = sum_gt9 ? sum_m10[3:0] : sum[3:0];
        next_work = work;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx == IW'(k)) next_work[k*4 +: 4] = res_nib;
        end
    end

    // Control FSM and working score; rst beats clear, clear beats everything else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            work     <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            pend     <= 1'b0;
            overflow <= 1'b0;
            pts      <= '0;
        end else if (clear) begin
            state    <= S_IDLE;
            work     <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            pend     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        pts.tens  <= clamp9(add_points[7:4]);
                        pts.units <= clamp9(add_points[3:0]);
                        idx       <= '0;
                        carry     <= 1'b0;
                        state     <= S_ADD;
                        // A frame arriving with the accepted add is served after it.
                        pend      <= frame_start;
                    end else if (frame_start) begin
                        state <= S_COMMIT;
                    end
                end
                S_ADD: begin
                    work  <= next_work;
                    idx   <= idx + IW'(1);
                    carry <= sum_gt9;
                    if (last_digit) begin
                        // Carry out of the MSD: pin the score at all nines.
                        if (sum_gt9) begin
                            work     <= ALL_NINES;
                            overflow <= 1'b1;
                        end
                        state <= (pend || frame_start) ? S_COMMIT : S_IDLE;
                        pend  <= 1'b0;
                    end else if (frame_start) begin
                        pend <= 1'b1;
                    end
                end
                S_COMMIT: begin
                    // Extra frame_start pulses here fold into this commit.
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Display registers: refreshed from the working score only in COMMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            digits  <= '0;
            hiscore <= '0;
        end else if (!clear && state == S_COMMIT) begin
            digits <= work;
            // Packed BCD orders the same as its decimal value.
            if (work > hiscore) hiscore <= work;
        end
    end

endmodule

// File: tb/tb_score_bcd_accum.sv
// Testbench for score_bcd_accum: decimal-level reference model, table-driven
// add vectors, hand sequences for multi-cycle corners, then random traffic.
module tb_score_bcd_accum;

    localparam int D    = 4;
    localparam int MAXV = 9999;

    logic           clk = 1'b0;
    logic           rst, clear, add_valid, frame_start;
    logic [7:0]     add_points;
    logic           add_ready, overflow;
    logic [D*4-1:0] digits, hiscore;

    int checks   = 0;
    int failures = 0;

    // Reference model state: plain decimal numbers plus a busy countdown.
    int m_w, m_dig, m_hi, m_target, m_busy;
    bit m_ovf, m_pend, m_commit, m_sat;

    always #5 clk = ~clk;

    score_bcd_accum #(.DIGITS(D)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .add_valid(add_valid), .add_ready(add_ready), .add_points(add_points),
        .frame_start(frame_start), .digits(digits), .hiscore(hiscore),
        .overflow(overflow)
    );

    typedef struct {
        int         init;
        logic [7:0] pts;
        int         exp_w;
        bit         exp_ovf;
    } vec_t;

    vec_t tbl[10];

    function automatic int clampd(input logic [3:0] n);
        return (n > 4'd9) ? 9 : int'(n);
    endfunction

    function automatic logic [D*4-1:0] to_bcd(input int v);
        logic [D*4-1:0] r;
        int t;
        r = '0;
        t = v;
        for (int k = 0; k < D; k++) begin
            r[k*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs in force at that edge.
    task automatic model_step();
        int sum;
        if (rst) begin
            m_w = 0; m_dig = 0; m_hi = 0; m_ovf = 0;
            m_busy = 0; m_pend = 0; m_commit = 0;
        end else if (clear) begin
            m_w = 0; m_ovf = 0; m_busy = 0; m_pend = 0; m_commit = 0;
        end else if (m_commit) begin
            m_dig = m_w;
            if (m_w > m_hi) m_hi = m_w;
            m_commit = 0;
        end else if (m_busy > 0) begin
            if (frame_start) m_pend = 1;
            m_busy--;
            if (m_busy == 0) begin
                m_w = m_sat ? MAXV : m_target;
                if (m_sat) m_ovf = 1;
                m_commit = m_pend;
                m_pend = 0;
            end
        end else if (add_valid) begin
            sum = m_w + clampd(add_points[3:0]) + 10 * clampd(add_points[7:4]);
            m_sat = (sum > MAXV);
            m_target = sum;
            m_busy = D;
            m_pend = frame_start;
        end else if (frame_start) begin
            m_commit = 1;
        end
    endtask

    // One clock: check ready before the edge, registered outputs after it.
    task automatic tick();
        #1;
        chk("add_ready", add_ready, (!rst && !clear && m_busy == 0 && !m_commit));
        @(posedge clk);
        model_step();
        #1;
        chk("digits", digits, to_bcd(m_dig));
        chk("hiscore", hiscore, to_bcd(m_hi));
        chk("overflow", overflow, m_ovf);
    endtask

    task automatic set_idle();
        clear = 0; add_valid = 0; frame_start = 0; add_points = 8'h00;
    endtask

    task automatic do_add(input logic [7:0] pts);
        add_valid  = 1;
        add_points = pts;
        tick();
        add_valid  = 0;
        for (int k = 0; k < D; k++) begin
            add_points = 8'($urandom);
            tick();
        end
    endtask

    task automatic do_commit();
        frame_start = 1;
        tick();
        frame_start = 0;
        tick();
    endtask

    task automatic set_w(input int v);
        int r, c;
        clear = 1;
        tick();
        clear = 0;
        r = v;
        while (r > 0) begin
            c = (r > 99) ? 99 : r;
            do_add(bcd8(c));
            r -= c;
        end
    endtask

    initial begin
        tbl[0] = '{0,    8'h25, 25,   0};
        tbl[1] = '{999,  8'h01, 1000, 0};
        tbl[2] = '{9990, 8'h15, 9999, 1};
        tbl[3] = '{100,  8'h50, 150,  0};
        tbl[4] = '{0,    8'hAF, 99,   0};
        tbl[5] = '{1234, 8'h00, 1234, 0};
        tbl[6] = '{9999, 8'h01, 9999, 1};
        tbl[7] = '{9900, 8'h99, 9999, 0};
        tbl[8] = '{9901, 8'h99, 9999, 1};
        tbl[9] = '{50,   8'h9A, 149,  0};

        set_idle();
        rst = 1;
        tick();
        tick();
        chk("rst_digits", digits, 0);
        chk("rst_hiscore", hiscore, 0);
        chk("rst_overflow", overflow, 0);
        rst = 0;
        #1 chk("rst_ready_after", add_ready, 1);

        // Basic add straight out of reset.
        do_add(8'h25);
        chk("basic_digits_before_commit", digits, 16'h0000);
        do_commit();
        chk("basic_digits", digits, 16'h0025);
        chk("basic_hiscore", hiscore, 16'h0025);

        // Table of start value / add / expected result.
        foreach (tbl[i]) begin
            set_w(tbl[i].init);
            do_add(tbl[i].pts);
            do_commit();
            chk("tbl_digits", digits, to_bcd(tbl[i].exp_w));
            chk("tbl_overflow", overflow, tbl[i].exp_ovf);
        end

        // Carry ripple: ready low for exactly D cycles after acceptance.
        set_w(999);
        add_valid = 1; add_points = 8'h01;
        tick();
        add_valid = 0;
        for (int k = 0; k < D; k++) begin
            #1 chk("ripple_busy", add_ready, 0);
            tick();
        end
        #1 chk("ripple_ready", add_ready, 1);
        do_commit();
        chk("ripple_digits", digits, 16'h1000);

        // Saturation, sticky overflow, then clear.
        set_w(9990);
        do_add(8'h15);
        chk("sat_overflow", overflow, 1);
        do_add(8'h01);
        do_commit();
        chk("sat_hold", digits, 16'h9999);
        chk("sat_hi", hiscore, 16'h9999);
        clear = 1;
        tick();
        clear = 0;
        chk("sat_cleared_ovf", overflow, 0);
        do_commit();
        chk("sat_cleared_digits", digits, 16'h0000);

        // Frame during the 2nd ADD cycle: no partial display, commit right after ADD.
        set_w(100);
        do_commit();
        chk("fda_pre", digits, 16'h0100);
        add_valid = 1; add_points = 8'h50;
        tick();
        add_valid = 0; add_points = 8'h99;
        tick();
        frame_start = 1;
        tick();
        frame_start = 0;
        chk("fda_mid", digits, 16'h0100);
        tick();
        chk("fda_mid2", digits, 16'h0100);
        tick();
        chk("fda_end_add", digits, 16'h0100);
        #1 chk("fda_commit_ready", add_ready, 0);
        tick();
        chk("fda_commit", digits, 16'h0150);
        #1 chk("fda_ready_after", add_ready, 1);

        // Invalid BCD add aborted by clear in its 3rd ADD cycle.
        add_valid = 1; add_points = 8'hAF;
        tick();
        add_valid = 0;
        tick();
        tick();
        clear = 1;
        #1 chk("clr_ready_low", add_ready, 0);
        tick();
        clear = 0;
        chk("clr_overflow", overflow, 0);
        #1 chk("clr_idle_ready", add_ready, 1);
        do_commit();
        chk("clr_digits", digits, 16'h0000);
        chk("clr_hiscore_kept", hiscore, 16'h9999);

        // Reset mid-ADD with add_valid held high.
        add_valid = 1; add_points = 8'h12;
        tick();
        tick();
        rst = 1;
        #1 chk("rstmid_ready", add_ready, 0);
        tick();
        chk("rstmid_digits", digits, 0);
        chk("rstmid_hiscore", hiscore, 0);
        chk("rstmid_overflow", overflow, 0);
        tick();
        rst = 0; add_valid = 0;
        #1 chk("rstmid_ready_after", add_ready, 1);
        do_add(8'h07);
        do_commit();
        chk("rstmid_fresh_add", digits, 16'h0007);

        // Random traffic against the model.
        for (int n = 0; n < 600; n++) begin
            rst         = ($urandom_range(0, 149) == 0);
            clear       = ($urandom_range(0, 49) == 0);
            add_valid   = $urandom_range(0, 1);
            add_points  = 8'($urandom);
            frame_start = ($urandom_range(0, 5) == 0);
            tick();
        end
        rst = 0;
        set_idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/score_bcd_accum.md
SCORE_BCD_ACCUM -- requirements
Module: score_bcd_accum

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning the number of BCD score digits; the legal range is 2..8.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port clear, input, 1 bit: new-game clear, synchronous, one-cycle pulse.
REQ-005 SHALL have port add_valid, input, 1 bit: a points-add request is present.
REQ-006 SHALL have port add_ready, output, 1 bit: the block can accept an add.
REQ-007 SHALL have port add_points, input, 8 bits: two BCD digits, [7:4] tens and [3:0] units.
REQ-008 SHALL have port frame_start, input, 1 bit: one-cycle pulse at the start of vertical blank.
REQ-009 SHALL have port digits, output, DIGITS*4 bits: the displayed score, packed BCD with the MSD in the top nibble; it feeds the score-draw stage directly.
REQ-010 SHALL have port hiscore, output, DIGITS*4 bits: the displayed high score, packed BCD.
REQ-011 SHALL have port overflow, output, 1 bit: sticky flag, set when the score has saturated.

Function
REQ-012 SHALL keep an internal working score W (DIGITS BCD nibbles) that is separate from the displayed digits.
REQ-013 SHALL implement three FSM states: IDLE, ADD and COMMIT.
REQ-014 SHALL drive add_ready high only in IDLE, with clear low and no commit pending.
REQ-015 SHALL accept an add on an edge where add_valid and add_ready are both high; at that edge it latches add_points, clamps any nibble >9 to 9, sets index i=0 and carry=0, and moves to ADD.
REQ-016 In ADD, SHALL process one digit per cycle, LSD first: s = W[i] + inc[i] + carry, where inc[0] is the units digit, inc[1] is the tens digit and inc[i>=2] is 0; if s>9 then W[i]=s-10 and carry=1, else W[i]=s and carry=0; then i increments.
REQ-017 SHALL complete ADD in exactly DIGITS cycles: an add accepted at edge T0 has final W at edge T_DIGITS, and add_ready is high again in the cycle after that edge.
REQ-018 If carry=1 after the MSD, SHALL set W to all 9s at the same edge and set overflow; further adds are still accepted but leave W at all 9s.
REQ-019 SHALL hold add_points internally once it is accepted, so changes on the input during ADD have no effect.
REQ-020 When frame_start arrives in IDLE, SHALL go to COMMIT for one cycle, then return to IDLE.
REQ-021 When frame_start arrives in ADD, SHALL set a pending flag and enter COMMIT on the edge that leaves ADD; it SHALL NOT accept a new add at that edge.
REQ-022 In COMMIT, SHALL load digits with W, and SHALL load hiscore with W if W > hiscore; the comparison is an unsigned compare of the packed vectors, which is valid for BCD.
REQ-023 SHALL update digits and hiscore only in COMMIT, so the display never shows a partial add.
REQ-024 SHALL merge a frame_start that arrives during COMMIT or while the flag is already pending into one commit.
REQ-025 On clear, SHALL take priority over add and frame_start: W goes to 0, overflow goes to 0, pending goes to 0, any ADD is aborted, the state goes to IDLE, and add_ready is low in the clear cycle.
REQ-026 On clear, SHALL leave digits and hiscore unchanged until the next COMMIT; hiscore is never cleared by clear.
REQ-027 SHALL treat add_points=0x00 as a legal add that takes the full DIGITS cycles and leaves W unchanged.
REQ-028 SHALL keep all outputs registered, with no combinational path from inputs to digits or hiscore.

Reset
REQ-029 On rst high at a clock edge, SHALL set W, digits and hiscore to 0, overflow to 0, pending to 0, the state to IDLE and add_ready to 0; add_ready goes to 1 in the first cycle after rst deasserts.
REQ-030 SHALL give rst priority over clear, add and frame_start, including when rst arrives mid-ADD or in COMMIT.

Verification
REQ-031 Basic add: with DIGITS=4 and W=0, add 0x25, then frame_start -> after 4 ADD cycles W=0025; digits=0x0025 one cycle after COMMIT; hiscore=0x0025.
REQ-032 Carry ripple: with W=0999, add 0x01 -> W=1000, with the carry crossing 3 digits; add_ready is low for exactly 4 cycles after acceptance.
REQ-033 Saturation: with W=9990, add 0x15 -> W=9999, overflow=1; a further add 0x01 keeps W=9999; clear then gives W=0000 and overflow=0.
REQ-034 Frame during add: assert frame_start in the 2nd ADD cycle of a 0x50 add onto 0100 -> digits never shows an intermediate value; COMMIT follows ADD and digits=0x0150.
REQ-035 Invalid BCD and clear mid-add: add 0xAF -> treated as 0x99; clear asserted in the 3rd ADD cycle -> W=0000, state IDLE, and hiscore keeps its prior value through the next COMMIT.
REQ-036 Reset mid-operation: rst during ADD with add_valid held high -> all outputs 0 at the next edge; no add is accepted in the rst cycle.
